// File: rtl/row_load_sequencer_if.sv
// row_load_sequencer_if: groups the UART byte input and the framebuffer write/status outputs
// Ports (slave = sequencer side): rx_data/rx_valid in; ram_wr_en/ram_wr_addr/ram_wr_data,
//   row_done, cmd_error, brightness_out, busy out. master is the mirror image (host/bench side).
interface row_load_sequencer_if #(
   parameter int ADDR_WIDTH = 11
) ();
   logic [7:0]            rx_data;
   logic                  rx_valid;
   logic                  ram_wr_en;
   logic [ADDR_WIDTH-1:0] ram_wr_addr;
   logic [15:0]           ram_wr_data;
   logic                  row_done;
   logic                  cmd_error;
   logic [7:0]            brightness_out;
   logic                  busy;

   modport slave (
      input  rx_data, rx_valid,
      output ram_wr_en, ram_wr_addr, ram_wr_data, row_done, cmd_error, brightness_out, busy
   );

   modport master (
      output rx_data, rx_valid,
      input  ram_wr_en, ram_wr_addr, ram_wr_data, row_done, cmd_error, brightness_out, busy
   );
endinterface

// File: rtl/row_load_sequencer.sv
// row_load_sequencer: decodes the host byte protocol ('L' row load, 'B' brightness) and turns
//   pixel byte pairs into single-cycle RGB565 framebuffer writes.
// Latency: write strobe 1 cycle after the low-byte rx_valid; all outputs registered.
// Backpressure: none; rx_valid strobes are consumed every cycle, an rx silence of
//   TIMEOUT_TICKS cycles mid-command aborts it with cmd_error.
// Ports: clk_in, reset (sync, active-high); bus (slave modport) carries rx_data/rx_valid in,
//   ram_wr_en/ram_wr_addr/ram_wr_data, row_done, cmd_error, brightness_out, busy out.
module row_load_sequencer #(
   parameter int                       ROW_ADDR_WIDTH   = 5,
   parameter int                       COL_ADDR_WIDTH   = 6,
   parameter int                       PIXELS_PER_ROW   = 64,
   parameter int                       ROWS             = 32,
   parameter int                       TIMEOUT_WIDTH    = 11,
   parameter logic [TIMEOUT_WIDTH-1:0] TIMEOUT_TICKS    = 11'd2000,
   parameter logic [7:0]               BRIGHTNESS_RESET = 8'hFF
) (
   input  logic                clk_in,
   input  logic                reset,
   row_load_sequencer_if.slave bus
);

   localparam int ADDR_W = ROW_ADDR_WIDTH + COL_ADDR_WIDTH;
   localparam int DISC_W = $clog2(2 * PIXELS_PER_ROW + 1);

   localparam logic [COL_ADDR_WIDTH-1:0] LAST_COL  = COL_ADDR_WIDTH'(PIXELS_PER_ROW - 1);
   localparam logic [DISC_W-1:0]         DISC_LOAD = DISC_W'(2 * PIXELS_PER_ROW);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_ROW_ADDR = 3'd1;
   localparam logic [2:0] S_PIX_HI   = 3'd2;
   localparam logic [2:0] S_PIX_LO   = 3'd3;
   localparam logic [2:0] S_BRIGHT   = 3'd4;
   localparam logic [2:0] S_DISCARD  = 3'd5;

   logic [2:0]                state_q,    state_d;
   logic [ROW_ADDR_WIDTH-1:0] row_q,      row_d;
   logic [COL_ADDR_WIDTH-1:0] col_q,      col_d;
   logic [7:0]                hi_q,       hi_d;
   logic [DISC_W-1:0]         disc_q,     disc_d;
   logic [TIMEOUT_WIDTH-1:0]  tmo_q,      tmo_d;
   logic                      wr_en_q,    wr_en_d;
   logic [ADDR_W-1:0]         wr_addr_q,  wr_addr_d;
   logic [15:0]               wr_data_q,  wr_data_d;
   logic                      row_done_q, row_done_d;
   logic                      err_q,      err_d;
   logic [7:0]                bright_q,   bright_d;
   logic                      busy_q,     busy_d;

   always_comb begin
      state_d    = state_q;
      row_d      = row_q;
      col_d      = col_q;
      hi_d       = hi_q;
      disc_d     = disc_q;
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      row_done_d = 1'b0;
      err_d      = 1'b0;
      bright_d   = bright_q;

      // Silence counter only runs while a command is in flight.
      if (bus.rx_valid || state_q == S_IDLE) begin
         tmo_d = '0;
      end else begin
         tmo_d = tmo_q + TIMEOUT_WIDTH'(1);
      end

      // A byte arriving on the expiry cycle wins over the timeout.
      if (state_q != S_IDLE && !bus.rx_valid && tmo_q == TIMEOUT_TICKS) begin
         err_d   = 1'b1;
         state_d = S_IDLE;
      end else if (bus.rx_valid) begin
         case (state_q)
            S_IDLE: begin
               if (bus.rx_data == 8'h4C) begin
                  state_d = S_ROW_ADDR;
               end else if (bus.rx_data == 8'h42) begin
                  state_d = S_BRIGHT;
               end
            end
            S_ROW_ADDR: begin
               if (int'(bus.rx_data) < ROWS) begin
                  row_d   = bus.rx_data[ROW_ADDR_WIDTH-1:0];
                  col_d   = '0;
                  state_d = S_PIX_HI;
               end else begin
                  // Swallow the bad row's payload so it is never parsed as commands.
                  err_d   = 1'b1;
                  disc_d  = DISC_LOAD;
                  state_d = S_DISCARD;
               end
            end
            S_PIX_HI: begin
               hi_d    = bus.rx_data;
               state_d = S_PIX_LO;
            end
            S_PIX_LO: begin
               wr_en_d   = 1'b1;
               wr_addr_d = {row_q, col_q};
               wr_data_d = {hi_q, bus.rx_data};
               if (col_q == LAST_COL) begin
                  row_done_d = 1'b1;
                  state_d    = S_IDLE;
               end else begin
                  col_d   = col_q + COL_ADDR_WIDTH'(1);
                  state_d = S_PIX_HI;
               end
            end
            S_BRIGHT: begin
               bright_d = bus.rx_data;
               state_d  = S_IDLE;
            end
            S_DISCARD: begin
               disc_d = disc_q - DISC_W'(1);
               if (disc_q == DISC_W'(1)) begin
                  state_d = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk_in) begin
      if (reset) begin
         state_q    <= S_IDLE;
         row_q      <= '0;
         col_q      <= '0;
         hi_q       <= '0;
         disc_q     <= '0;
         tmo_q      <= '0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         row_done_q <= 1'b0;
         err_q      <= 1'b0;
         bright_q   <= BRIGHTNESS_RESET;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         row_q      <= row_d;
         col_q      <= col_d;
         hi_q       <= hi_d;
         disc_q     <= disc_d;
         tmo_q      <= tmo_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         row_done_q <= row_done_d;
         err_q      <= err_d;
         bright_q   <= bright_d;
         busy_q     <= busy_d;
      end
   end

   assign bus.ram_wr_en      = wr_en_q;
   assign bus.ram_wr_addr    = wr_addr_q;
   assign bus.ram_wr_data    = wr_data_q;
   assign bus.row_done       = row_done_q;
   assign bus.cmd_error      = err_q;
   assign bus.brightness_out = bright_q;
   assign bus.busy           = busy_q;

endmodule

// File: tb/tb_row_load_sequencer.sv
// tb_row_load_sequencer: directed byte streams; expected framebuffer writes (address, data,
//   row_done flag, arrival cycle) are queued by the stimulus and checked by a negedge monitor.
module tb_row_load_sequencer;

   logic clk_in = 1'b0;
   logic reset  = 1'b1;
   always #5 clk_in = ~clk_in;

   row_load_sequencer_if #(.ADDR_WIDTH(11)) bus ();

   row_load_sequencer dut (
      .clk_in (clk_in),
      .reset  (reset),
      .bus    (bus)
   );

   typedef struct {
      logic [10:0] addr;
      logic [15:0] data;
      logic        done;
      int          cyc;
   } exp_t;

   exp_t exp_q[$];
   int   tests   = 0;
   int   fails   = 0;
   int   cyc     = 0;
   int   wr_cnt  = 0;
   int   rd_cnt  = 0;
   int   err_cnt = 0;
   int   err_cyc = 0;

   always @(posedge clk_in) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   // Monitor: scoreboard pop on every write strobe, pulse counters for row_done/cmd_error.
   always @(negedge clk_in) begin
      exp_t e;
      if (bus.ram_wr_en === 1'b1) begin
         wr_cnt++;
         if (exp_q.size() == 0) begin
            check("unexpected_write", {5'd0, bus.ram_wr_addr, bus.ram_wr_data}, 32'hFFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            check("wr_addr", 32'(bus.ram_wr_addr), 32'(e.addr));
            check("wr_data", 32'(bus.ram_wr_data), 32'(e.data));
            check("wr_row_done", 32'(bus.row_done), 32'(e.done));
            check("wr_latency_cycle", cyc, e.cyc);
         end
      end else if (bus.row_done === 1'b1) begin
         check("row_done_without_write", 32'd1, 32'd0);
      end
      if (bus.row_done === 1'b1) rd_cnt++;
      if (bus.cmd_error === 1'b1) begin
         err_cnt++;
         err_cyc = cyc;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   task automatic send(input logic [7:0] b);
      @(negedge clk_in);
      bus.rx_valid = 1'b1;
      bus.rx_data  = b;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk_in);
         bus.rx_valid = 1'b0;
      end
   endtask

   task automatic do_reset();
      @(negedge clk_in);
      bus.rx_valid = 1'b0;
      reset = 1'b1;
      idle(2);
      reset = 1'b0;
   endtask

   // Sends one pixel pair and queues the write expected one cycle after the low byte.
   task automatic pixel(input logic [4:0] r, input int c, input logic [7:0] hi,
                        input logic [7:0] lo, input int gap);
      exp_t e;
      send(hi);
      if (gap > 0) idle(gap);
      send(lo);
      e.addr = {r, 6'(c)};
      e.data = {hi, lo};
      e.done = (c == 63);
      e.cyc  = cyc + 1;
      exp_q.push_back(e);
      if (gap > 0) idle(gap);
   endtask

   // Full row: pixel n = {hi, lo_base + n}.
   task automatic row_load(input logic [4:0] r, input logic [7:0] hi,
                           input logic [7:0] lo_base, input int gap);
      send(8'h4C);
      if (gap > 0) idle(gap);
      send({3'd0, r});
      if (gap > 0) idle(gap);
      for (int c = 0; c < 64; c++) pixel(r, c, hi, 8'(lo_base + 8'(c)), gap);
   endtask

   task automatic settle(input string name, input int exp_wr, input int exp_rd, input int exp_err);
      idle(3);
      check({name, "_queue_empty"}, exp_q.size(), 0);
      check({name, "_write_count"}, wr_cnt, exp_wr);
      check({name, "_row_done_count"}, rd_cnt, exp_rd);
      check({name, "_cmd_error_count"}, err_cnt, exp_err);
      check({name, "_busy_idle"}, 32'(bus.busy), 0);
   endtask

   initial begin
      int t0;
      bit seen;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      idle(3);
      reset = 1'b0;
      idle(1);

      // Reset state
      check("rst_wr_en",     32'(bus.ram_wr_en), 0);
      check("rst_wr_addr",   32'(bus.ram_wr_addr), 0);
      check("rst_wr_data",   32'(bus.ram_wr_data), 0);
      check("rst_row_done",  32'(bus.row_done), 0);
      check("rst_cmd_error", 32'(bus.cmd_error), 0);
      check("rst_busy",      32'(bus.busy), 0);
      check("rst_bright",    32'(bus.brightness_out), 32'h00FF);

      // 1: row 3, pixel n = 0x98nn, a gap cycle between bytes
      send(8'h4C);
      idle(1);
      send(8'h03);
      idle(1);
      check("t1_busy_mid", 32'(bus.busy), 1);
      for (int c = 0; c < 64; c++) pixel(5'd3, c, 8'h98, 8'(c), 1);
      settle("t1", 64, 1, 0);

      // 2: bad row 0x20, payload of command-looking bytes must be discarded
      send(8'h4C);
      send(8'h20);
      for (int i = 0; i < 128; i++) send((i % 2 == 0) ? 8'h4C : 8'h42);
      idle(3);
      check("t2_err_once", err_cnt, 1);
      check("t2_no_writes", wr_cnt, 64);
      check("t2_bright_unchanged", 32'(bus.brightness_out), 32'h00FF);
      row_load(5'd0, 8'h11, 8'h80, 0);
      settle("t2", 128, 2, 1);

      // 3: truncated row, timeout then a fresh row starts at column 0
      send(8'h4C);
      send(8'h05);
      send(8'h12);
      t0 = cyc + 1;
      seen = 0;
      for (int i = 0; i < 2200 && !seen; i++) begin
         idle(1);
         if (i == 1000) check("t3_busy_waiting", 32'(bus.busy), 1);
         if (err_cnt == 2) seen = 1;
      end
      check("t3_timeout_seen", 32'(seen), 1);
      check("t3_timeout_latency_ok", 32'((err_cyc - t0) >= 1999 && (err_cyc - t0) <= 2002), 1);
      idle(1);
      check("t3_busy_after_timeout", 32'(bus.busy), 0);
      check("t3_no_partial_write", wr_cnt, 128);
      row_load(5'd5, 8'h3C, 8'h00, 0);
      settle("t3", 192, 3, 2);

      // 4: brightness set, then reset restores default
      send(8'h42);
      send(8'h40);
      idle(2);
      check("t4_bright", 32'(bus.brightness_out), 32'h0040);
      check("t4_no_write", wr_cnt, 192);
      do_reset();
      idle(1);
      check("t4_bright_after_reset", 32'(bus.brightness_out), 32'h00FF);

      // 5: padding then two rows back to back, no idle cycles
      send(8'h00);
      send(8'h00);
      send(8'h00);
      row_load(5'd31, 8'hA5, 8'h40, 0);
      row_load(5'd0,  8'h5A, 8'hC0, 0);
      settle("t5", 320, 5, 2);

      // 6: reset after pixel 10, following row starts at column 0
      send(8'h4C);
      send(8'h07);
      for (int c = 0; c <= 10; c++) pixel(5'd7, c, 8'hE0, 8'(c), 0);
      do_reset();
      idle(4);
      check("t6_no_write_after_reset", wr_cnt, 331);
      check("t6_busy_after_reset", 32'(bus.busy), 0);
      row_load(5'd9, 8'h07, 8'h20, 0);
      settle("t6", 395, 6, 2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
